// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg : shared FSM state type and idle output value for uart_tx_queue
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } tx_state_e;

  localparam logic [8:0] TX_IDLE_VALUE = 9'h1FF;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with stall enable, occupancy level, wrap pointers
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (en) begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (en && do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_queue.sv
//------------------------------------------------------------------------------
// uart_tx_queue : MMIO byte queue feeding a toggle-strobe UART transmitter
// Optional sent_count statistics enabled by macro UART_TX_QUEUE_STATS_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_enable,
  input  logic                   wr_valid,
  input  logic [7:0]             wr_data,
  output logic                   wr_ready,
  input  logic                   uart_tx_sending,
  output logic [8:0]             uart_tx_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_overflow,
  output logic [31:0]            sent_count
);

  tx_state_e  state;
  tx_state_e  state_nxt;
  logic       pop;
  logic       full;
  logic       empty;
  logic [7:0] head;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .en      (clk_enable),
    .push    (wr_valid),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign wr_ready = ~full;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !uart_tx_sending) begin
          pop       = 1'b1;
          state_nxt = WAIT_START;
        end
      end
      WAIT_START: if (uart_tx_sending)  state_nxt = WAIT_DONE;
      WAIT_DONE:  if (!uart_tx_sending) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)             state <= IDLE;
    else if (clk_enable) state <= state_nxt;
  end

  // Bit 8 is a toggle strobe: the transmitter starts on any change of it.
  always_ff @(posedge clk) begin
    if (rst)                    uart_tx_data <= TX_IDLE_VALUE;
    else if (clk_enable && pop) uart_tx_data <= {~uart_tx_data[8], head};
  end

  // A dropped write outranks a clear request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (clk_enable) begin
      if (wr_valid && full) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

`ifdef UART_TX_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                    sent_count <= '0;
    else if (clk_enable && pop) sent_count <= sent_count + 32'd1;
  end
`else
  assign sent_count = '0;
`endif

endmodule

`default_nettype wire
